// File: rtl/chimera_pkg.sv
// Shared types and default constants for the external-cluster power sequencer.
//
// Contents:
//   ExtClusters           number of externally sequenced clusters
//   Def*                  default timing constants used by chimera_clu_pwr_seq
//   CntWidth              width of the shared wait/hold counter
//   clu_pwr_e             target power state of one cluster
//   seq_state_e           sequencer FSM states
package chimera_pkg;

    localparam int unsigned ExtClusters        = 5;
    localparam int unsigned DefIsoTimeout      = 255;
    localparam int unsigned DefClkSettleCycles = 2;
    localparam int unsigned DefRstHoldCycles   = 4;
    localparam int unsigned CntWidth           = 8;

    typedef enum logic [0:0] {
        CluOff = 1'b0,
        CluOn  = 1'b1
    } clu_pwr_e;

    typedef enum logic [2:0] {
        SeqIdle,
        SeqIsoOn,
        SeqClkOff,
        SeqRstOn,
        SeqClkOn,
        SeqRstOff,
        SeqIsoOff
    } seq_state_e;

endpackage

// File: rtl/chimera_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request found by
// searching upward from ptr_i with wrap-around.
//
// Ports:
//   req_i     request vector
//   ptr_i     index where the search starts (must be < N)
//   valid_o   at least one request is asserted
//   idx_o     index of the selected request
//   onehot_o  one-hot form of idx_o, all zero when valid_o is low
module chimera_rr_pick #(
    parameter int unsigned N    = 5,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o,
    output logic [N-1:0]    onehot_o
);

    always_comb begin
        int unsigned cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(cand);
            end
        end
        onehot_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// Power sequencer for the external cluster domain. Per-cluster power-up/down requests
// are arbitrated round-robin onto a single sequencer which orders isolation, clock
// gating and reset for the granted cluster, qualifying the isolation steps with the
// cluster's isolation acknowledge.
//
// Ports:
//   clk_i         SoC clock
//   rst_i         synchronous active-high reset
//   req_valid_i   per-cluster request valid, held until req_ready_o
//   req_on_i      requested state per cluster (1 = up, 0 = down), sampled at grant
//   req_ready_o   one-cycle one-hot grant pulse
//   iso_ack_i     isolation acknowledge from the cluster domain
//   clu_iso_o     isolate request per cluster
//   clu_clk_en_o  clock-gate enable per cluster (1 = clock runs)
//   clu_rst_no    active-low cluster reset
//   clu_on_o      cluster fully powered up
//   busy_o        sequencer not idle
//   timeout_o     sticky isolation-acknowledge timeout flags
//   err_clr_i     clears timeout_o (a same-cycle new timeout still sets its bit)
module chimera_clu_pwr_seq
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters     = ExtClusters,
    parameter int unsigned IsoTimeout      = DefIsoTimeout,
    parameter int unsigned ClkSettleCycles = DefClkSettleCycles,
    parameter int unsigned RstHoldCycles   = DefRstHoldCycles
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] req_valid_i,
    input  logic [NumClusters-1:0] req_on_i,
    output logic [NumClusters-1:0] req_ready_o,
    input  logic [NumClusters-1:0] iso_ack_i,
    output logic [NumClusters-1:0] clu_iso_o,
    output logic [NumClusters-1:0] clu_clk_en_o,
    output logic [NumClusters-1:0] clu_rst_no,
    output logic [NumClusters-1:0] clu_on_o,
    output logic                   busy_o,
    output logic [NumClusters-1:0] timeout_o,
    input  logic                   err_clr_i
);

    localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

    // Counters start at zero on state entry, so each limit is "cycles - 1".
    localparam logic [CntWidth-1:0] IsoLimit    = CntWidth'(IsoTimeout - 1);
    localparam logic [CntWidth-1:0] SettleLimit = CntWidth'(ClkSettleCycles - 1);
    localparam logic [CntWidth-1:0] HoldLimit   = CntWidth'(RstHoldCycles - 1);

    seq_state_e             state_q;
    seq_state_e             launch_q;
    logic [IdxW-1:0]        ptr_q;
    logic [IdxW-1:0]        sel_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [NumClusters-1:0] ready_q;
    logic [NumClusters-1:0] iso_q;
    logic [NumClusters-1:0] clk_en_q;
    logic [NumClusters-1:0] rst_n_q;
    logic [NumClusters-1:0] on_q;
    logic [NumClusters-1:0] to_q;

    logic                   pick_valid;
    logic [IdxW-1:0]        pick_idx;
    logic [NumClusters-1:0] pick_onehot;
    clu_pwr_e               pick_target;
    seq_state_e             pick_launch;
    logic                   ack_sel;
    logic                   iso_wait;
    logic [NumClusters-1:0] to_set;

    chimera_rr_pick #(
        .N    (NumClusters),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i    (req_valid_i),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // Decide at grant time where the sequence starts; a request for the state the
    // cluster is already in is granted but launches nothing.
    always_comb begin
        pick_target = clu_pwr_e'(req_on_i[pick_idx]);
        if (pick_target == clu_pwr_e'(on_q[pick_idx])) begin
            pick_launch = SeqIdle;
        end else if (pick_target == CluOn) begin
            pick_launch = SeqClkOn;
        end else begin
            pick_launch = SeqIsoOn;
        end
    end

    assign ack_sel = iso_ack_i[sel_q];

    // Still waiting for the expected acknowledge level in one of the iso states.
    assign iso_wait = ((state_q == SeqIsoOn) && !ack_sel) ||
                      ((state_q == SeqIsoOff) && ack_sel);

    always_comb begin
        to_set = '0;
        if (iso_wait && (cnt_q == IsoLimit)) begin
            to_set[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SeqIdle;
            launch_q <= SeqIdle;
            ptr_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= '0;
            iso_q    <= '1;
            clk_en_q <= '0;
            rst_n_q  <= '0;
            on_q     <= '0;
            to_q     <= '0;
        end else begin
            ready_q <= '0;
            // A new timeout wins over a simultaneous clear.
            to_q    <= (err_clr_i ? '0 : to_q) | to_set;

            unique case (state_q)
                SeqIdle: begin
                    if (ready_q != '0) begin
                        // Grant cycle just ended: start the latched sequence. No new
                        // arbitration here, the granted valid is still visible.
                        cnt_q <= '0;
                        if (launch_q == SeqClkOn) begin
                            state_q         <= SeqClkOn;
                            clk_en_q[sel_q] <= 1'b1;
                        end else if (launch_q == SeqIsoOn) begin
                            state_q      <= SeqIsoOn;
                            iso_q[sel_q] <= 1'b1;
                        end
                    end else if (pick_valid) begin
                        ready_q  <= pick_onehot;
                        sel_q    <= pick_idx;
                        launch_q <= pick_launch;
                        ptr_q    <= (pick_idx == IdxW'(NumClusters - 1)) ?
                                    '0 : pick_idx + 1'b1;
                    end
                end

                SeqIsoOn: begin
                    if (!iso_wait || (cnt_q == IsoLimit)) begin
                        state_q         <= SeqClkOff;
                        cnt_q           <= '0;
                        clk_en_q[sel_q] <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                SeqClkOff: begin
                    if (cnt_q == SettleLimit) begin
                        state_q        <= SeqRstOn;
                        cnt_q          <= '0;
                        rst_n_q[sel_q] <= 1'b0;
                        on_q[sel_q]    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                SeqRstOn: begin
                    state_q <= SeqIdle;
                end

                SeqClkOn: begin
                    if (cnt_q == HoldLimit) begin
                        state_q        <= SeqRstOff;
                        cnt_q          <= '0;
                        rst_n_q[sel_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                SeqRstOff: begin
                    if (cnt_q == SettleLimit) begin
                        state_q      <= SeqIsoOff;
                        cnt_q        <= '0;
                        iso_q[sel_q] <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                SeqIsoOff: begin
                    if (!iso_wait || (cnt_q == IsoLimit)) begin
                        state_q     <= SeqIdle;
                        cnt_q       <= '0;
                        on_q[sel_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= SeqIdle;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign clu_iso_o    = iso_q;
    assign clu_clk_en_o = clk_en_q;
    assign clu_rst_no   = rst_n_q;
    assign clu_on_o     = on_q;
    assign timeout_o    = to_q;
    assign busy_o       = (state_q != SeqIdle);

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// Self-checking bench for chimera_clu_pwr_seq. A behavioural model tracks each
// cluster's power state, the round-robin pointer and the timeout flags, and predicts
// the per-cycle output timeline of every sequence from the step durations.
module tb_chimera_clu_pwr_seq;

    localparam int N  = 5;
    localparam int RH = 4;
    localparam int CS = 2;
    localparam int TO = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_on;
    logic [N-1:0] req_ready;
    logic [N-1:0] iso_ack;
    logic [N-1:0] clu_iso;
    logic [N-1:0] clu_clk_en;
    logic [N-1:0] clu_rst_n;
    logic [N-1:0] clu_on;
    logic         busy;
    logic [N-1:0] timeout;
    logic         err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit           m_on [N];
    int           m_ptr;
    logic [N-1:0] m_to;

    chimera_clu_pwr_seq #(
        .NumClusters     (N),
        .IsoTimeout      (TO),
        .ClkSettleCycles (CS),
        .RstHoldCycles   (RH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_on_i     (req_on),
        .req_ready_o  (req_ready),
        .iso_ack_i    (iso_ack),
        .clu_iso_o    (clu_iso),
        .clu_clk_en_o (clu_clk_en),
        .clu_rst_no   (clu_rst_n),
        .clu_on_o     (clu_on),
        .busy_o       (busy),
        .timeout_o    (timeout),
        .err_clr_i    (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] m_onvec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_on[i];
        return v;
    endfunction

    function automatic int model_pick(input logic [N-1:0] mask);
        for (int j = 0; j < N; j++) begin
            if (mask[(m_ptr + j) % N]) return (m_ptr + j) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_to  = '0;
        for (int i = 0; i < N; i++) m_on[i] = 1'b0;
    endtask

    task automatic test_reset();
        logic [6*N:0] act, exp;
        rst       = 1'b1;
        req_valid = '0;
        req_on    = '0;
        iso_ack   = '1;
        err_clr   = 1'b0;
        step();
        step();
        act = {clu_iso, clu_clk_en, clu_rst_n, clu_on, req_ready, timeout, busy};
        exp = {{N{1'b1}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}, 1'b0};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", act, exp);
        end
        rst = 1'b0;
        model_reset();
        step();
        n_chk++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b expected 0/0", busy, req_ready);
        end
    endtask

    // Drive one request (other valids may already be pending), then follow the whole
    // sequence cycle by cycle against the predicted timeline.
    task automatic test_sequence(input int idx, input bit on, input int d, input bit clr_at_to);
        int w, iso_e, x, endk, to_k, lat;
        bit noop, tout;
        logic [N-1:0] s_iso, s_clk, s_rst, s_on;
        logic [N-1:0] e_iso, e_clk, e_rst, e_on, e_rdy, e_to;
        logic e_busy;
        logic [6*N:0] act, exp;

        noop  = (on == m_on[idx]);
        tout  = (d >= TO);
        lat   = tout ? TO : d + 1;
        iso_e = 0;
        x     = 0;
        to_k  = -1;
        if (noop) begin
            endk = 1;
        end else if (on) begin
            iso_e = 1 + RH + CS;
            x     = iso_e + lat;
            endk  = x;
        end else begin
            iso_e = 1;
            x     = iso_e + lat;
            endk  = x + CS + 1;
        end
        if (!noop && tout) to_k = x;

        s_on  = m_onvec();
        s_iso = ~s_on;
        s_clk = s_on;
        s_rst = s_on;
        e_to  = m_to;

        req_valid[idx] = 1'b1;
        req_on[idx]    = on;
        w = 0;
        do begin
            step();
            w++;
        end while (req_ready === '0 && w < 20);
        n_chk++;
        if (w != 1 || req_ready !== (N'(1) << idx)) begin
            n_fail++;
            $display("FAIL grant c%0d: got ready=%b after %0d cycles, expected %b after 1",
                     idx, req_ready, w, N'(1) << idx);
            if (req_ready === '0) begin
                req_valid[idx] = 1'b0;
                return;
            end
        end
        m_ptr = (idx + 1) % N;
        req_valid[idx] = 1'b0;
        req_on[idx]    = 1'($urandom);  // must be ignored after grant

        for (int k = 0; k <= endk; k++) begin
            if (k > 0) step();
            e_iso = s_iso;
            e_clk = s_clk;
            e_rst = s_rst;
            e_on  = s_on;
            if (!noop && k >= 1) begin
                if (on) begin
                    e_iso[idx] = (k < iso_e);
                    e_clk[idx] = 1'b1;
                    e_rst[idx] = (k >= 1 + RH);
                    e_on[idx]  = (k >= x);
                end else begin
                    e_iso[idx] = 1'b1;
                    e_clk[idx] = (k < x);
                    e_rst[idx] = (k < x + CS);
                    e_on[idx]  = (k < x + CS);
                end
            end
            e_rdy  = (k == 0) ? (N'(1) << idx) : '0;
            e_busy = !noop && (k >= 1) && (k < endk);
            if (clr_at_to && k == to_k) e_to = '0;
            if (k == to_k) e_to[idx] = 1'b1;

            act = {clu_iso, clu_clk_en, clu_rst_n, clu_on, req_ready, timeout, busy};
            exp = {e_iso, e_clk, e_rst, e_on, e_rdy, e_to, e_busy};
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL seq c%0d on=%0d k=%0d: got %h expected %h (iso,clk,rst,on,rdy,to,busy)",
                         idx, on, k, act, exp);
            end

            err_clr = clr_at_to && (k + 1 == to_k);
            if (!noop && !tout && k == iso_e + d) iso_ack[idx] = !on;
        end
        err_clr      = 1'b0;
        iso_ack[idx] = !on;
        m_on[idx]    = on;
        m_to         = e_to;
    endtask

    task automatic test_multi(input logic [N-1:0] mask, input logic [N-1:0] onv, input int d);
        logic [N-1:0] pend;
        int idx;
        req_on    = onv;
        req_valid = mask;
        pend      = mask;
        while (pend != '0) begin
            idx       = model_pick(pend);
            pend[idx] = 1'b0;
            test_sequence(idx, onv[idx], d, 1'b0);
        end
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_chk++;
        if (timeout !== '0) begin
            n_fail++;
            $display("FAIL err_clr: got timeout=%b expected %b", timeout, {N{1'b0}});
        end
        m_to = '0;
    endtask

    task automatic test_timeout();
        if (!m_on[1]) test_sequence(1, 1'b1, 2, 1'b0);
        test_sequence(1, 1'b0, 999, 1'b0);   // ack never rises: forced progress
        test_err_clr();
        test_sequence(1, 1'b1, 999, 1'b0);   // ack never falls: flag 1 set again
        if (!m_on[4]) test_sequence(4, 1'b1, 1, 1'b0);
        test_sequence(4, 1'b0, 999, 1'b1);   // clear coincides with new timeout
        test_err_clr();
    endtask

    task automatic test_reset_midseq();
        logic [6*N:0] act, exp;
        if (m_on[0]) test_sequence(0, 1'b0, 1, 1'b0);
        req_valid[0] = 1'b1;
        req_on[0]    = 1'b1;
        step();
        n_chk++;
        if (req_ready !== N'(1)) begin
            n_fail++;
            $display("FAIL midseq_grant: got ready=%b expected %b", req_ready, N'(1));
        end
        req_valid[0] = 1'b0;
        step();
        step();
        n_chk++;
        if (clu_clk_en[0] !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midseq_clk_on: got clk_en0=%b busy=%b expected 1/1", clu_clk_en[0], busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        act = {clu_iso, clu_clk_en, clu_rst_n, clu_on, req_ready, timeout, busy};
        exp = {{N{1'b1}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}, 1'b0};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL midseq_reset: got %h expected %h", act, exp);
        end
        model_reset();
        iso_ack = '1;
    endtask

    task automatic test_random();
        int idx, d;
        bit on;
        logic [N-1:0] mask;
        for (int it = 0; it < 16; it++) begin
            idx    = $urandom_range(N - 1);
            on     = 1'($urandom);
            d      = $urandom_range(5);
            req_on = N'($urandom);
            test_sequence(idx, on, d, 1'b0);
        end
        for (int it = 0; it < 3; it++) begin
            mask = N'($urandom_range((1 << N) - 1, 1));
            test_multi(mask, N'($urandom), $urandom_range(4));
        end
    endtask

    initial begin
        test_reset();
        test_sequence(2, 1'b1, 3, 1'b0);          // power-up cluster 2
        test_sequence(2, 1'b0, 1, 1'b0);          // power-down cluster 2
        test_sequence(0, 1'b0, 0, 1'b0);          // redundant power-down, pointer -> 1
        test_multi(5'b11001, 5'b11001, 2);        // grants 3, 4, 0
        test_timeout();
        test_reset_midseq();
        test_multi(5'b11111, 5'b10110, 1);        // pointer back at 0 after reset
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
